// File: rtl/pipe_pkg.sv
// Shared pipeline types and encodings used by the hazard/forwarding controller.
package pipe_pkg;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic [1:0] resultsrc;
  } stage_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one ALU operand; M-stage producer beats W-stage.
module hazard_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output logic [1:0] fwd
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs_e))
      sel = FWD_M;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e))
      sel = FWD_W;
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: stall/flush generation, shadow E/M/W
// tracking, forwarding selects, perf counters and a sticky rd_e cross-check.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             regwrite_d,
  input  logic [1:0]       resultsrc_d,
  input  logic             pcsrc_e,
  input  logic [4:0]       rd_e_dp,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             sync_err
);

  stage_t     e_q;
  logic [4:0] m_rd, w_rd;
  logic       m_rw, w_rw;
  logic       lw_stall;
  logic [1:0] fwd_a, fwd_b;

  hazard_fwd_sel u_fwd_a (
    .rs_e       (e_q.rs1),
    .rd_m       (m_rd),
    .regwrite_m (m_rw),
    .rd_w       (w_rd),
    .regwrite_w (w_rw),
    .fwd        (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e       (e_q.rs2),
    .rd_m       (m_rd),
    .regwrite_m (m_rw),
    .rd_w       (w_rd),
    .regwrite_w (w_rw),
    .fwd        (fwd_b)
  );

  assign lw_stall = (e_q.resultsrc == RESULT_LOAD) && (e_q.rd != '0) &&
                    ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

  // A taken branch wins over a load-use stall so the PC can take the target.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b1;
    flush_e    = 1'b1;
    forward_ae = FWD_REG;
    forward_be = FWD_REG;
    if (!rst) begin
      stall_f    = lw_stall & ~pcsrc_e;
      stall_d    = lw_stall & ~pcsrc_e;
      flush_d    = pcsrc_e;
      flush_e    = lw_stall | pcsrc_e;
      forward_ae = fwd_a;
      forward_be = fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      m_rd      <= '0;
      m_rw      <= 1'b0;
      w_rd      <= '0;
      w_rw      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (flush_e)
        e_q <= '0;
      else
        e_q <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                 regwrite: regwrite_d, resultsrc: resultsrc_d};
      m_rd <= e_q.rd;
      m_rw <= e_q.regwrite;
      w_rd <= m_rd;
      w_rw <= m_rw;
      if (stall_f && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pcsrc_e && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (CHECK_EN && (rd_e_dp != e_q.rd))
        sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a queue scoreboard of expected outputs.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic             regwrite_d;
  logic [1:0]       resultsrc_d;
  logic             pcsrc_e;
  logic [4:0]       rd_e_dp;
  logic             stall_f, stall_d, flush_d, flush_e;
  logic [1:0]       forward_ae, forward_be;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             sync_err;

  hazard_ctrl #(.CNT_W(CNT_W), .CHECK_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .regwrite_d  (regwrite_d),
    .resultsrc_d (resultsrc_d),
    .pcsrc_e     (pcsrc_e),
    .rd_e_dp     (rd_e_dp),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .forward_ae  (forward_ae),
    .forward_be  (forward_be),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] rsrc;
    logic       pc;
    logic       dp_bad;
    logic       e_st, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  typedef struct {
    int         idx;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
  } exp_t;

  vec_t       tbl[$];
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_rd_e = '0;

  function automatic vec_t mk(logic r, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                              logic w, logic [1:0] rs, logic p,
                              logic st, logic fd, logic fe, logic [1:0] fa, logic [1:0] fb);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.rw = w; v.rsrc = rs; v.pc = p;
    v.dp_bad = 1'b0;
    v.e_st = st; v.e_fd = fd; v.e_fe = fe; v.e_fa = fa; v.e_fb = fb;
    return v;
  endfunction

  function automatic vec_t nop(logic p);
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, p, 1'b0, p, p, 2'b00, 2'b00);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e, got;
    @(negedge clk);
    rst         = v.rst;
    rs1_d       = v.rs1;
    rs2_d       = v.rs2;
    rd_d        = v.rd;
    regwrite_d  = v.rw;
    resultsrc_d = v.rsrc;
    pcsrc_e     = v.pc;
    rd_e_dp     = v.dp_bad ? 5'd7 : exp_rd_e;
    e.idx = idx; e.st = v.e_st; e.fd = v.e_fd; e.fe = v.e_fe; e.fa = v.e_fa; e.fb = v.e_fb;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      checks++;
      if (stall_f !== got.st || stall_d !== got.st || flush_d !== got.fd ||
          flush_e !== got.fe || forward_ae !== got.fa || forward_be !== got.fb) begin
        errors++;
        $display("FAIL vec%0d: got sf=%b sd=%b fd=%b fe=%b fa=%b fb=%b expected sf=sd=%b fd=%b fe=%b fa=%b fb=%b",
                 got.idx, stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be,
                 got.st, got.fd, got.fe, got.fa, got.fb);
      end
    end
    exp_rd_e = (v.rst || v.e_fe) ? 5'd0 : v.rd;
  endtask

  task automatic run(input int from, input int to);
    for (int i = from; i <= to; i++) apply(i, tbl[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // 0-2 reset held two cycles
    tbl.push_back(mk(1, 5, 5, 5, 1, 2'b01, 0, 0, 1, 1, 2'b00, 2'b00));
    tbl.push_back(mk(1, 5, 5, 5, 1, 2'b01, 0, 0, 1, 1, 2'b00, 2'b00));
    tbl.push_back(nop(0));
    // 3-9 M over W priority
    tbl.push_back(mk(0, 1, 2, 5, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 2, 5, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 5, 7, 6, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 5, 8, 1, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    // 10-15 load-use on x3
    tbl.push_back(mk(0, 1, 0, 3, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 3, 4, 1, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 3, 4, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    // 16-20 load to x0 then reader of x0
    tbl.push_back(mk(0, 1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 0, 0, 9, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    // 21-25 load-use coinciding with taken branch
    tbl.push_back(mk(0, 1, 0, 3, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 3, 4, 1, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    // 26-29 datapath rd_e disagreement
    tbl.push_back(mk(0, 1, 2, 4, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    v = nop(0); v.dp_bad = 1'b1; tbl.push_back(v);
    tbl.push_back(nop(0));
    tbl.push_back(nop(0));
    // 30-33 reset in the middle of a load-use pair
    tbl.push_back(mk(0, 1, 0, 3, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00));
    tbl.push_back(mk(0, 1, 3, 4, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(nop(0));
    // 34-54 branch held 20 cycles, then idle
    for (int i = 0; i < 20; i++) tbl.push_back(nop(1));
    tbl.push_back(nop(0));

    run(0, 2);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    chk("rst_sync_err", int'(sync_err), 0);

    run(3, 9);
    run(10, 15);
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    run(16, 20);
    chk("x0_stall_cnt", int'(stall_cnt), 1);

    run(21, 25);
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 1);
    chk("br_sync_err", int'(sync_err), 0);

    run(26, 28);
    chk("sync_err_set", int'(sync_err), 1);
    run(29, 29);
    chk("sync_err_sticky", int'(sync_err), 1);

    run(30, 33);
    chk("midrst_sync_err", int'(sync_err), 0);
    chk("midrst_stall_cnt", int'(stall_cnt), 0);
    chk("midrst_flush_cnt", int'(flush_cnt), 0);

    run(34, 54);
    chk("sat_flush_cnt", int'(flush_cnt), 15);
    chk("sat_stall_cnt", int'(stall_cnt), 0);
    chk("sat_sync_err", int'(sync_err), 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
